// File: rtl/ft_arb_pkg.sv
// ft_arb_pkg
//   Shared definitions for the FTDI bus arbiter: FSM state encoding,
//   direction constants used by last_dir, and counter widths.
package ft_arb_pkg;

  // Arbiter FSM states. RX_OE is the one-cycle bus-turn phase in which the
  // FTDI is allowed to drive the data bus before the RX grant is issued.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_OE    = 3'd1,
    S_RX_GRANT = 3'd2,
    S_TX_GRANT = 3'd3,
    S_TURN     = 3'd4
  } arb_state_t;

  // last_dir encoding.
  localparam logic DIR_TX = 1'b0;
  localparam logic DIR_RX = 1'b1;

  // Burst counter width (covers MAX_BURST up to 65535).
  localparam int CNT_W = 16;

  // Turnaround down-counter width (covers TURNAROUND up to 15).
  localparam int TURN_W = 4;

endpackage : ft_arb_pkg

// File: rtl/ft_bus_arbiter.sv
// ft_bus_arbiter
//   Shares the FTDI synchronous-FIFO data bus between the receive path
//   (FTDI -> FPGA) and the transmit path (FPGA -> FTDI). Grants are bounded
//   to MAX_BURST beats when the opposite direction is waiting, and every
//   release is followed by TURNAROUND dead cycles before the next grant.
//
// Parameters
//   MAX_BURST  : beats per grant before preemption (1..65535)
//   TURNAROUND : idle cycles after each release (1..15)
//
// Ports
//   clk, rst           : FTDI clock, asynchronous active-high reset
//   rx_req, tx_req     : direction wants the bus
//   rx_beat, tx_beat   : one byte transferred this cycle
//   rx_done, tx_done   : voluntary release of the current grant
//   err_clr            : synchronous clear of err
//   rx_oe              : FTDI may drive the data bus
//   rx_grant, tx_grant : direction owns the data bus
//   busy               : arbiter not in IDLE
//   last_dir           : most recently granted direction (0 = TX, 1 = RX)
//   err                : sticky protocol error (beat without grant)
//   state, burst_cnt   : observation of FSM state and burst counter
//
// Handshake: a requester holds *_req high while it has work. Once *_grant
// is high, each cycle with *_beat high is one transferred byte and is
// counted, including the cycle in which the grant is being released. A
// requester releases by dropping *_req or pulsing *_done; the grant falls
// on the following edge. A beat seen while its grant is low is an error.
module ft_bus_arbiter
  import ft_arb_pkg::*;
#(
  parameter int MAX_BURST  = 64,
  parameter int TURNAROUND = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_req,
  input  logic             tx_req,
  input  logic             rx_beat,
  input  logic             tx_beat,
  input  logic             rx_done,
  input  logic             tx_done,
  input  logic             err_clr,
  output logic             rx_oe,
  output logic             rx_grant,
  output logic             tx_grant,
  output logic             busy,
  output logic             last_dir,
  output logic             err,
  output arb_state_t       state,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_BURST);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND);

  arb_state_t        state_nxt;
  logic [TURN_W-1:0] turn_cnt;
  logic              in_grant;
  logic              own_req;
  logic              own_beat;
  logic              own_done;
  logic              other_req;
  logic [CNT_W:0]    beat_sum;
  logic              grant_exit;
  logic              err_set;

  // Exit test for the grant currently held. beat_sum includes this cycle's
  // beat so a burst ending exactly on MAX_BURST releases in that cycle.
  always_comb begin
    in_grant  = 1'b0;
    own_req   = 1'b0;
    own_beat  = 1'b0;
    own_done  = 1'b0;
    other_req = 1'b0;
    case (state)
      S_RX_GRANT: begin
        in_grant  = 1'b1;
        own_req   = rx_req;
        own_beat  = rx_beat;
        own_done  = rx_done;
        other_req = tx_req;
      end
      S_TX_GRANT: begin
        in_grant  = 1'b1;
        own_req   = tx_req;
        own_beat  = tx_beat;
        own_done  = tx_done;
        other_req = rx_req;
      end
      default: ;
    endcase
    beat_sum   = {1'b0, burst_cnt} + {{CNT_W{1'b0}}, own_beat};
    grant_exit = !own_req || own_done ||
                 ((beat_sum >= {1'b0, MAX_CNT}) && other_req);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // With both requests pending, alternate away from last_dir.
        if (rx_req && (!tx_req || (last_dir == DIR_TX)))
          state_nxt = S_RX_OE;
        else if (tx_req)
          state_nxt = S_TX_GRANT;
      end
      S_RX_OE:    state_nxt = S_RX_GRANT;
      S_RX_GRANT,
      S_TX_GRANT: if (grant_exit) state_nxt = S_TURN;
      S_TURN:     if (turn_cnt <= TURN_W'(1)) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  assign err_set = (rx_beat && !rx_grant) || (tx_beat && !tx_grant);

  // State, registered outputs and counters. Outputs are decoded from the
  // next state so they change on the same edge as the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rx_oe     <= 1'b0;
      rx_grant  <= 1'b0;
      tx_grant  <= 1'b0;
      busy      <= 1'b0;
      last_dir  <= DIR_TX;
      err       <= 1'b0;
      burst_cnt <= '0;
      turn_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      rx_oe    <= (state_nxt == S_RX_OE) || (state_nxt == S_RX_GRANT);
      rx_grant <= (state_nxt == S_RX_GRANT);
      tx_grant <= (state_nxt == S_TX_GRANT);
      busy     <= (state_nxt != S_IDLE);

      if (in_grant && grant_exit)
        last_dir <= (state == S_RX_GRANT) ? DIR_RX : DIR_TX;

      // Counts during a grant and saturates at MAX_BURST; any non-grant
      // state clears it, so every grant starts from zero.
      if (in_grant) begin
        if (own_beat && (burst_cnt != MAX_CNT))
          burst_cnt <= burst_cnt + CNT_W'(1);
      end else begin
        burst_cnt <= '0;
      end

      if (in_grant && grant_exit)
        turn_cnt <= TURN_LOAD;
      else if ((state == S_TURN) && (turn_cnt != '0))
        turn_cnt <= turn_cnt - TURN_W'(1);

      // Set has priority over clear.
      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule : ft_bus_arbiter

// File: tb/tb_ft_bus_arbiter.sv
// tb_ft_bus_arbiter
//   Self-checking bench for ft_bus_arbiter with MAX_BURST=4, TURNAROUND=2.
//   A directed vector table, hand-written multi-cycle sequences and a
//   randomized run, all checked against a behavioural reference model.
module tb_ft_bus_arbiter;
  import ft_arb_pkg::*;

  localparam int MB = 4;
  localparam int TA = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic rx_req, tx_req, rx_beat, tx_beat, rx_done, tx_done, err_clr;
  logic rx_oe, rx_grant, tx_grant, busy, last_dir, err;
  arb_state_t dut_state;
  logic [CNT_W-1:0] burst_cnt;

  ft_bus_arbiter #(.MAX_BURST(MB), .TURNAROUND(TA)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_req   (rx_req),
    .tx_req   (tx_req),
    .rx_beat  (rx_beat),
    .tx_beat  (tx_beat),
    .rx_done  (rx_done),
    .tx_done  (tx_done),
    .err_clr  (err_clr),
    .rx_oe    (rx_oe),
    .rx_grant (rx_grant),
    .tx_grant (tx_grant),
    .busy     (busy),
    .last_dir (last_dir),
    .err      (err),
    .state    (dut_state),
    .burst_cnt(burst_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the observable bus ownership directly: who holds the bus, how
  // many dead cycles remain, and how many beats the holder has moved.
  bit m_oe, m_rxg, m_txg, m_last, m_err;
  int m_turn, m_beats;

  task automatic model_reset();
    m_oe = 0; m_rxg = 0; m_txg = 0; m_last = 0; m_err = 0;
    m_turn = 0; m_beats = 0;
  endtask

  task automatic model_step();
    bit o_req, o_beat, o_done, x_req, leave;
    int total;
    if ((rx_beat && !m_rxg) || (tx_beat && !m_txg)) m_err = 1;
    else if (err_clr) m_err = 0;
    if (m_rxg || m_txg) begin
      o_req  = m_rxg ? rx_req  : tx_req;
      o_beat = m_rxg ? rx_beat : tx_beat;
      o_done = m_rxg ? rx_done : tx_done;
      x_req  = m_rxg ? tx_req  : rx_req;
      total  = m_beats + (o_beat ? 1 : 0);
      leave  = !o_req || o_done || (total >= MB && x_req);
      m_beats = (total > MB) ? MB : total;
      if (leave) begin
        m_last = m_rxg;
        m_rxg = 0; m_txg = 0; m_oe = 0;
        m_turn = TA;
      end
    end else if (m_oe) begin
      m_rxg = 1; m_beats = 0;
    end else if (m_turn > 0) begin
      m_turn--;
    end else if (rx_req || tx_req) begin
      if (rx_req && (!tx_req || !m_last)) m_oe = 1;
      else begin m_txg = 1; m_beats = 0; end
    end
  endtask

  function automatic logic [5:0] model_vec();
    return {m_oe, m_rxg, m_txg, (m_oe | m_rxg | m_txg | (m_turn > 0)), m_last, m_err};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {rx_oe, rx_grant, tx_grant, busy, last_dir, err};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rr, input bit tr, input bit rb, input bit tb,
                       input bit rd, input bit td, input bit cl);
    rx_req = rr; tx_req = tr; rx_beat = rb; tx_beat = tb;
    rx_done = rd; tx_done = td; err_clr = cl;
  endtask

  // One clock: model follows the edge, outputs are compared 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_outputs", 32'(dut_vec()), 32'(model_vec()));
    if (m_rxg || m_txg) check("burst_cnt", 32'(burst_cnt), 32'(m_beats));
    check("oe_tx_overlap", 32'(rx_oe & tx_grant), 32'd0);
    check("grant_overlap", 32'(rx_grant & tx_grant), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    check("reset_burst", 32'(burst_cnt), 32'd0);
    check("reset_state", 32'(dut_state), 32'(S_IDLE));
  endtask

  // ---------------- directed vector table ----------------
  // exp bits: {rx_oe, rx_grant, tx_grant, busy, last_dir, err} after the edge.
  typedef struct {
    bit rr, tr, rb, tb, rd, td, cl;
    logic [5:0] exp;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  task automatic set_vec(input int i, input bit rr, input bit tr, input bit rb,
                         input bit tb, input bit rd, input bit td, input bit cl,
                         input logic [5:0] e);
    vecs[i].rr = rr; vecs[i].tr = tr; vecs[i].rb = rb; vecs[i].tb = tb;
    vecs[i].rd = rd; vecs[i].td = td; vecs[i].cl = cl; vecs[i].exp = e;
  endtask

  int rx_run, tx_run, rx_bursts, tx_bursts;
  bit first_seen;
  bit first_is_rx;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    //           rr tr rb tb rd td cl  oe rg tg bz ld er
    set_vec( 0,  0, 1, 0, 0, 0, 0, 0, 6'b001100); // tx grant one cycle later
    set_vec( 1,  0, 0, 0, 0, 0, 1, 0, 6'b000100); // tx_done -> TURN
    set_vec( 2,  0, 0, 0, 0, 0, 0, 0, 6'b000100); // second TURN cycle
    set_vec( 3,  0, 0, 0, 0, 0, 0, 0, 6'b000000); // IDLE
    set_vec( 4,  1, 0, 0, 0, 0, 0, 0, 6'b100100); // rx_oe at +1
    set_vec( 5,  1, 0, 0, 0, 0, 0, 0, 6'b110100); // rx_grant at +2
    set_vec( 6,  1, 0, 1, 0, 0, 0, 0, 6'b110100); // granted beat
    set_vec( 7,  0, 0, 0, 0, 0, 0, 0, 6'b000110); // rx_req drop -> release
    set_vec( 8,  0, 0, 0, 0, 0, 0, 0, 6'b000110);
    set_vec( 9,  0, 0, 0, 0, 0, 0, 0, 6'b000010);
    set_vec(10,  0, 0, 1, 0, 0, 0, 0, 6'b000011); // beat without grant
    set_vec(11,  0, 0, 0, 0, 0, 0, 0, 6'b000011); // sticky
    set_vec(12,  0, 0, 0, 0, 0, 0, 1, 6'b000010); // clear
    set_vec(13,  0, 0, 0, 1, 0, 0, 1, 6'b000011); // set beats clear
    set_vec(14,  0, 0, 0, 0, 0, 0, 1, 6'b000010);
    set_vec(15,  1, 1, 0, 0, 0, 0, 0, 6'b001110); // both, last RX -> TX
    set_vec(16,  1, 1, 0, 1, 0, 0, 0, 6'b001110); // beat 1
    set_vec(17,  1, 1, 0, 1, 0, 0, 0, 6'b001110); // beat 2
    set_vec(18,  1, 1, 0, 1, 0, 0, 0, 6'b001110); // beat 3
    set_vec(19,  1, 1, 0, 1, 0, 0, 0, 6'b000100); // beat 4 -> preempt
    set_vec(20,  1, 1, 0, 0, 0, 0, 0, 6'b000100); // requests ignored in TURN
    set_vec(21,  1, 1, 0, 0, 0, 0, 0, 6'b000000);
    set_vec(22,  1, 1, 0, 0, 0, 0, 0, 6'b100100); // alternates back to RX

    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rr, vecs[i].tr, vecs[i].rb, vecs[i].tb,
            vecs[i].rd, vecs[i].td, vecs[i].cl);
      tick();
      check($sformatf("vec%0d", i), 32'(dut_vec()), 32'(vecs[i].exp));
    end

    // ---- both requests held, beats whenever granted: 4-beat alternation ----
    do_reset();
    rx_run = 0; tx_run = 0; rx_bursts = 0; tx_bursts = 0;
    first_seen = 0; first_is_rx = 0;
    drive(1, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 60; c++) begin
      tick();
      if (!first_seen && (rx_grant || tx_grant)) begin
        first_seen = 1; first_is_rx = rx_grant;
      end
      if (rx_grant) rx_run++;
      else if (rx_run != 0) begin
        check("rx_burst_len", 32'(rx_run), 32'(MB)); rx_bursts++; rx_run = 0;
      end
      if (tx_grant) tx_run++;
      else if (tx_run != 0) begin
        check("tx_burst_len", 32'(tx_run), 32'(MB)); tx_bursts++; tx_run = 0;
      end
      drive(1, 1, rx_grant, tx_grant, 0, 0, 0);
    end
    check("first_grant_rx", 32'(first_is_rx), 32'd1);
    check("rx_bursts_seen", 32'(rx_bursts >= 3), 32'd1);
    check("tx_bursts_seen", 32'(tx_bursts >= 3), 32'd1);
    check("alt_no_err", 32'(err), 32'd0);

    // ---- only tx_req: grant runs past MAX_BURST, count saturates ----
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick();
    check("tx_only_grant", 32'(tx_grant), 32'd1);
    for (int b = 0; b < 10; b++) begin
      drive(0, 1, 0, 1, 0, 0, 0);
      tick();
      check("tx_only_held", 32'(tx_grant), 32'd1);
    end
    check("tx_only_sat", 32'(burst_cnt), 32'(MB));
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("tx_only_release", 32'(tx_grant), 32'd0);
    repeat (3) tick();

    // ---- done and beat together: beat counted, then released ----
    drive(1, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(1, 0, 1, 0, 0, 0, 0);
    tick();
    drive(1, 0, 1, 0, 1, 0, 0);
    tick();
    check("done_beat_release", 32'(rx_grant), 32'd0);
    check("done_beat_no_err", 32'(err), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();

    // ---- asynchronous reset mid RX grant ----
    drive(1, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(1, 0, 1, 0, 0, 0, 0);
    tick();
    check("pre_rst_rx_grant", 32'(rx_grant), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rx_grant", 32'(rx_grant), 32'd0);
    check("async_rst_rx_oe", 32'(rx_oe), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    check("post_rst_rx_first", 32'({rx_oe, tx_grant}), 32'b10);
    tick();
    check("post_rst_rx_grant", 32'(rx_grant), 32'd1);

    // ---- randomized run against the model ----
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 6,
            $urandom_range(0, 9) < 6,
            rx_grant ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 99) < 3),
            tx_grant ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 99) < 3),
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0);
      tick();
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ft_bus_arbiter

// File: doc/ft_bus_arbiter.md
FT_BUS_ARBITER -- requirements
Module: ft_bus_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 64: beats per grant before preemption when the other direction is waiting; legal range 1..65535.
REQ-002 Parameter TURNAROUND, default 2: idle cycles between any release and the next grant; legal range 1..15.
REQ-003 clk  in  1  single clock for all state; the block runs in the FTDI clock domain.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rx_req  in  1  FTDI has receive data and an input ping-pong FIFO is activated.
REQ-006 tx_req  in  1  output ping-pong FIFO is activated with data and FTDI TXE is asserted.
REQ-007 rx_beat  in  1  one byte moved FTDI->FIFO this cycle.
REQ-008 tx_beat  in  1  one byte moved FIFO->FTDI this cycle.
REQ-009 rx_done / tx_done  in  1 each  requester voluntarily releases its grant.
REQ-010 rx_oe  out  1  FTDI output enable (bus driven by FTDI).
REQ-011 rx_grant / tx_grant  out  1 each  direction owns the data bus.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 last_dir  out  1  0 = TX, 1 = RX; direction most recently granted.
REQ-014 err  out  1  sticky protocol error; err_clr  in  1  clears it synchronously.

Function
REQ-015 States: IDLE, RX_OE, RX_GRANT, TX_GRANT, TURN; all outputs are registered.
REQ-016 IDLE, one request only: go to that direction's path; both requests: pick the direction opposite last_dir.
REQ-017 RX path: IDLE->RX_OE (rx_oe=1, rx_grant=0, exactly 1 cycle)->RX_GRANT (rx_oe=1, rx_grant=1); rx_grant rises 2 cycles after rx_req is sampled in IDLE.
REQ-018 TX path: IDLE->TX_GRANT (tx_grant=1, rx_oe=0); tx_grant rises 1 cycle after tx_req is sampled in IDLE.
REQ-019 rx_oe and tx_grant are never high in the same cycle, and rx_grant and tx_grant are never high together.
REQ-020 16-bit burst counter: cleared on grant entry; increments on the owning direction's beat; saturates at MAX_BURST and never wraps.
REQ-021 Grant exit, evaluated each grant cycle, when any of the following holds: own req low; own done high; (count + beat) >= MAX_BURST and the other req is high.
REQ-022 On exit, grant and rx_oe drop on the next edge, last_dir updates to the exiting direction, and the state goes to TURN.
REQ-023 A beat in the final grant cycle, including the cycle that meets the exit condition, is valid and counted.
REQ-024 With the other req low, a grant continues past MAX_BURST and the count holds at MAX_BURST.
REQ-025 TURN lasts exactly TURNAROUND cycles (4-bit down-counter) and then enters IDLE; requests during TURN are not granted.
REQ-026 A beat while its grant is low sets err; err_clr and a set event in the same cycle leave err = 1 (set wins).
REQ-027 Simultaneous done and beat: the beat is counted, then exit.

Reset
REQ-028 Asynchronous assertion forces state IDLE, rx_oe=0, rx_grant=0, tx_grant=0, busy=0, last_dir=0, err=0, burst and turn counters=0.
REQ-029 Reset asserted mid-grant drops all grants immediately, without waiting for a clock edge; no TURN is served after reset release.
REQ-030 First grant after reset with both requests high is RX (last_dir=0).

Structure
REQ-031 Package ft_arb_pkg holds the state encoding, the DIR_RX/DIR_TX constants and the counter width (16).
REQ-032 No sub-module; counters and the FSM are inline in ft_bus_arbiter.

Verification
REQ-033 tx_req pulses high from IDLE -> tx_grant=1 one cycle later; tx_done -> tx_grant=0 next cycle, busy stays high 2 TURN cycles, then IDLE.
REQ-034 rx_req high -> rx_oe=1 at +1, rx_grant=1 at +2; rx_req drops -> rx_oe=0 and rx_grant=0 on the next edge.
REQ-035 MAX_BURST=4, both reqs held, beats every cycle -> RX 4 beats, 2 idle, TX 4 beats, 2 idle, RX ..., no overlap of rx_oe and tx_grant.
REQ-036 MAX_BURST=4, only tx_req, 10 beats -> tx_grant held for all 10 beats, count stays 4.
REQ-037 rx_beat with rx_grant=0 -> err=1 and held; err_clr -> err=0 next cycle; err_clr with a simultaneous bad beat -> err stays 1.
REQ-038 rst asserted mid-RX_GRANT -> rx_grant and rx_oe low before the next edge; after release with both reqs high, RX is granted first.
